// File: rtl/serial_mod_pkg.sv
// Shared helpers for the serial mod-N checker: remainder width and the single-step reduction.
package serial_mod_pkg;

  // Wide enough for 2*D-1 with D up to 255.
  localparam int unsigned ArithW = 9;

  function automatic int unsigned rem_width(input int unsigned d);
    return (d < 2) ? 1 : $clog2(d);
  endfunction

  // Operands are always below 2*d, so one conditional subtract completes the reduction.
  function automatic logic [ArithW-1:0] mod_add_reduce(input logic [ArithW-1:0] x,
                                                       input logic [ArithW-1:0] d);
    return (x >= d) ? x - d : x;
  endfunction

endpackage

// File: rtl/serial_mod_ch.sv
// One channel of the serial divisibility checker: running remainder, bit weight, counter.
module serial_mod_ch
  import serial_mod_pkg::*;
#(
  parameter int unsigned DIVISOR   = 3,
  parameter int unsigned LSB_FIRST = 0,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned REM_W     = rem_width(DIVISOR)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  input  logic             in_start,
  input  logic             din,
  output logic             dout,
  output logic [REM_W-1:0] rem,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             empty
);

  localparam logic [ArithW-1:0] DivA = ArithW'(DIVISOR);
  localparam logic [REM_W-1:0]  Wgt1 = REM_W'(1);
  localparam logic [REM_W-1:0]  Wgt2 = REM_W'(mod_add_reduce(ArithW'(2), DivA));

  logic [REM_W-1:0] rem_q, wgt_q, rem_next, wgt_next;
  logic [REM_W:0]   msb_sum, lsb_sum, wgt_dbl;
  logic [CNT_W-1:0] cnt_q, cnt_inc;
  logic             empty_q;

  always_comb begin
    msb_sum  = {rem_q, din};
    lsb_sum  = {1'b0, rem_q} + {1'b0, (din ? wgt_q : '0)};
    wgt_dbl  = {wgt_q, 1'b0};
    rem_next = (LSB_FIRST != 0) ? REM_W'(mod_add_reduce(ArithW'(lsb_sum), DivA))
                                : REM_W'(mod_add_reduce(ArithW'(msb_sum), DivA));
    wgt_next = REM_W'(mod_add_reduce(ArithW'(wgt_dbl), DivA));
    cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rem_q   <= '0;
      wgt_q   <= Wgt1;
      cnt_q   <= '0;
      empty_q <= 1'b1;
    end else if (in_start && in_valid) begin
      // The value restarts with this bit, so the next bit carries weight 2.
      rem_q   <= REM_W'(din);
      wgt_q   <= Wgt2;
      cnt_q   <= CNT_W'(1);
      empty_q <= 1'b0;
    end else if (in_start) begin
      rem_q   <= '0;
      wgt_q   <= Wgt1;
      cnt_q   <= '0;
      empty_q <= 1'b1;
    end else if (in_valid) begin
      rem_q   <= rem_next;
      wgt_q   <= wgt_next;
      cnt_q   <= cnt_inc;
      empty_q <= 1'b0;
    end
  end

  assign dout    = !empty_q && (rem_q == '0);
  assign rem     = rem_q;
  assign bit_cnt = cnt_q;
  assign empty   = empty_q;

endmodule

// File: rtl/serial_mod_n_checker.sv
// Multi-channel bit-serial divisibility checker; one independent serial_mod_ch per channel.
module serial_mod_n_checker
  import serial_mod_pkg::*;
#(
  parameter int unsigned DIVISOR   = 3,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned LSB_FIRST = 0,
  parameter int unsigned CNT_W     = 16,
  localparam int unsigned REM_W    = rem_width(DIVISOR)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH-1:0]       in_start,
  input  logic [NUM_CH-1:0]       din,
  output logic [NUM_CH-1:0]       dout,
  output logic [NUM_CH*REM_W-1:0] rem,
  output logic [NUM_CH*CNT_W-1:0] bit_cnt,
  output logic [NUM_CH-1:0]       empty
);

  if (DIVISOR < 2 || DIVISOR > 255 || NUM_CH < 1 || NUM_CH > 16) begin : g_param_err
    $error("serial_mod_n_checker: illegal DIVISOR=%0d or NUM_CH=%0d", DIVISOR, NUM_CH);
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    serial_mod_ch #(
      .DIVISOR  (DIVISOR),
      .LSB_FIRST(LSB_FIRST),
      .CNT_W    (CNT_W),
      .REM_W    (REM_W)
    ) u_ch (
      .clk     (clk),
      .resetn  (resetn),
      .in_valid(in_valid[c]),
      .in_start(in_start[c]),
      .din     (din[c]),
      .dout    (dout[c]),
      .rem     (rem[c*REM_W +: REM_W]),
      .bit_cnt (bit_cnt[c*CNT_W +: CNT_W]),
      .empty   (empty[c])
    );
  end

endmodule

// File: tb/tb_serial_mod_n_checker.sv
// Directed and random bench for serial_mod_n_checker over three configurations sharing stimulus.
module tb_serial_mod_n_checker;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  in_valid, in_start, din;
  logic [3:0]  dout0, dout1, dout2, empty0, empty1, empty2;
  logic [7:0]  rem0;
  logic [11:0] rem1, rem2;
  logic [63:0] cnt0, cnt1;
  logic [11:0] cnt2;

  always #5 clk = ~clk;

  // D=3 MSB-first, D=7 LSB-first, D=5 MSB-first with a 3-bit counter.
  serial_mod_n_checker #(.DIVISOR(3), .NUM_CH(4), .LSB_FIRST(0), .CNT_W(16)) u_msb3 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_start(in_start), .din(din),
    .dout(dout0), .rem(rem0), .bit_cnt(cnt0), .empty(empty0));
  serial_mod_n_checker #(.DIVISOR(7), .NUM_CH(4), .LSB_FIRST(1), .CNT_W(16)) u_lsb7 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_start(in_start), .din(din),
    .dout(dout1), .rem(rem1), .bit_cnt(cnt1), .empty(empty1));
  serial_mod_n_checker #(.DIVISOR(5), .NUM_CH(4), .LSB_FIRST(0), .CNT_W(3)) u_sat (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_start(in_start), .din(din),
    .dout(dout2), .rem(rem2), .bit_cnt(cnt2), .empty(empty2));

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned md[3]   = '{3, 7, 5};
  bit          ml[3]   = '{1'b0, 1'b1, 1'b0};
  int unsigned mmax[3] = '{65535, 65535, 7};
  int unsigned m_rem[3][4], m_wgt[3][4], m_cnt[3][4];
  bit          m_empty[3][4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_rem(input int d, input int c);
    case (d)
      0:       return 32'(rem0[c*2 +: 2]);
      1:       return 32'(rem1[c*3 +: 3]);
      default: return 32'(rem2[c*3 +: 3]);
    endcase
  endfunction

  function automatic logic [31:0] get_cnt(input int d, input int c);
    case (d)
      0:       return 32'(cnt0[c*16 +: 16]);
      1:       return 32'(cnt1[c*16 +: 16]);
      default: return 32'(cnt2[c*3 +: 3]);
    endcase
  endfunction

  function automatic logic [31:0] get_bit(input int d, input int c, input bit is_empty);
    case (d)
      0:       return 32'(is_empty ? empty0[c] : dout0[c]);
      1:       return 32'(is_empty ? empty1[c] : dout1[c]);
      default: return 32'(is_empty ? empty2[c] : dout2[c]);
    endcase
  endfunction

  // Reference: value mod D built from the arithmetic definition of the bit stream.
  task automatic model_update();
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < 4; c++) begin
        if (!resetn || (in_start[c] && !in_valid[c])) begin
          m_rem[d][c] = 0; m_wgt[d][c] = 1; m_cnt[d][c] = 0; m_empty[d][c] = 1'b1;
        end else if (in_start[c] && in_valid[c]) begin
          m_rem[d][c] = din[c]; m_wgt[d][c] = 2 % md[d]; m_cnt[d][c] = 1; m_empty[d][c] = 1'b0;
        end else if (in_valid[c]) begin
          if (ml[d]) begin
            m_rem[d][c] = (m_rem[d][c] + (din[c] ? m_wgt[d][c] : 0)) % md[d];
            m_wgt[d][c] = (m_wgt[d][c] * 2) % md[d];
          end else begin
            m_rem[d][c] = (m_rem[d][c] * 2 + din[c]) % md[d];
          end
          if (m_cnt[d][c] < mmax[d]) m_cnt[d][c]++;
          m_empty[d][c] = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < 4; c++) begin
        check($sformatf("d%0d_c%0d_rem", d, c), get_rem(d, c), m_rem[d][c]);
        check($sformatf("d%0d_c%0d_cnt", d, c), get_cnt(d, c), m_cnt[d][c]);
        check($sformatf("d%0d_c%0d_empty", d, c), get_bit(d, c, 1'b1), 32'(m_empty[d][c]));
        check($sformatf("d%0d_c%0d_dout", d, c), get_bit(d, c, 1'b0),
              32'(!m_empty[d][c] && m_rem[d][c] == 0));
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_dout0"}, 32'(dout0), 0);   check({tag, "_empty0"}, 32'(empty0), 15);
    check({tag, "_rem0"}, 32'(rem0), 0);     check({tag, "_cnt0"}, cnt0[31:0], 0);
    check({tag, "_dout1"}, 32'(dout1), 0);   check({tag, "_empty1"}, 32'(empty1), 15);
    check({tag, "_rem1"}, 32'(rem1), 0);     check({tag, "_cnt1"}, cnt1[31:0], 0);
    check({tag, "_dout2"}, 32'(dout2), 0);   check({tag, "_empty2"}, 32'(empty2), 15);
    check({tag, "_rem2"}, 32'(rem2), 0);     check({tag, "_cnt2"}, 32'(cnt2), 0);
  endtask

  initial begin
    logic [31:0] exp_rem[9];
    logic [31:0] exp_cnt[9];
    logic [8:0]  sat_bits;

    resetn = 1'b0; in_valid = '0; in_start = '0; din = '0;
    tick(); tick();
    check_reset_state("reset");
    resetn = 1'b1;

    // D=3 MSB-first, ch0 bits 1,1,0.
    in_valid = 4'b0001;
    din = 4'b0001; tick();
    check("msb3_b1_rem", get_rem(0, 0), 1); check("msb3_b1_dout", 32'(dout0[0]), 0);
    check("msb3_b1_cnt", get_cnt(0, 0), 1);
    din = 4'b0001; tick();
    check("msb3_b2_rem", get_rem(0, 0), 0); check("msb3_b2_dout", 32'(dout0[0]), 1);
    check("msb3_b2_cnt", get_cnt(0, 0), 2);
    din = 4'b0000; tick();
    check("msb3_b3_rem", get_rem(0, 0), 0); check("msb3_b3_dout", 32'(dout0[0]), 1);
    check("msb3_b3_cnt", get_cnt(0, 0), 3);
    check_all();

    // D=7 LSB-first, ch1 bits 1,1,1 then 1.
    in_valid = 4'b0010; din = 4'b0010;
    tick(); check("lsb7_b1_rem", get_rem(1, 1), 1); check("lsb7_b1_dout", 32'(dout1[1]), 0);
    tick(); check("lsb7_b2_rem", get_rem(1, 1), 3); check("lsb7_b2_dout", 32'(dout1[1]), 0);
    tick(); check("lsb7_b3_rem", get_rem(1, 1), 0); check("lsb7_b3_dout", 32'(dout1[1]), 1);
    tick(); check("lsb7_b4_rem", get_rem(1, 1), 1); check("lsb7_b4_dout", 32'(dout1[1]), 0);
    check_all();

    // Restart mid-stream on ch2 of the D=3 instance.
    in_valid = 4'b0100;
    din = 4'b0100; tick();
    din = 4'b0000; tick();
    check("rst_pre_rem", get_rem(0, 2), 2);
    in_start = 4'b0100; din = 4'b0100; tick();
    check("start_v_rem", get_rem(0, 2), 1); check("start_v_cnt", get_cnt(0, 2), 1);
    check("start_v_empty", 32'(empty0[2]), 0);
    in_valid = 4'b0000; tick();
    check("start_empty", 32'(empty0[2]), 1); check("start_dout", 32'(dout0[2]), 0);
    check("start_cnt", get_cnt(0, 2), 0);
    in_start = 4'b0000;
    check_all();

    // Random streams on all channels with valid gaps and occasional restarts.
    for (int i = 0; i < 1400; i++) begin
      for (int c = 0; c < 4; c++) begin
        in_valid[c] = ($urandom_range(0, 3) != 0);
        in_start[c] = ($urandom_range(0, 63) == 0);
        din[c]      = 1'($urandom_range(0, 1));
      end
      tick();
      check_all();
    end

    // Reset mid-stream while bits are presented.
    in_start = '0; in_valid = 4'hF; din = 4'hF; resetn = 1'b0;
    tick();
    check_reset_state("midreset");
    resetn = 1'b1;
    tick();
    check("post_rst_rem3", get_rem(0, 0), 1); check("post_rst_cnt3", get_cnt(0, 0), 1);
    check("post_rst_rem7", get_rem(1, 3), 1); check("post_rst_dout7", 32'(dout1[3]), 0);
    check_all();

    // Counter saturation on the 3-bit-counter instance, D=5 MSB-first, value 0b101101110.
    sat_bits = 9'b101101110;
    exp_rem  = '{1, 2, 0, 1, 2, 0, 1, 3, 1};
    exp_cnt  = '{1, 2, 3, 4, 5, 6, 7, 7, 7};
    in_valid = 4'b0001;
    for (int k = 0; k < 9; k++) begin
      in_start = (k == 0) ? 4'b0001 : 4'b0000;
      din      = {3'b000, sat_bits[8-k]};
      tick();
      check($sformatf("sat_rem_%0d", k), get_rem(2, 0), exp_rem[k]);
      check($sformatf("sat_cnt_%0d", k), get_cnt(2, 0), exp_cnt[k]);
      check_all();
    end
    in_valid = '0; in_start = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
